// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and limits for the instruction loader
package loader_pkg;

  localparam int LOADER_MAX_WORDS = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } LoaderState;

endpackage

// File: rtl/loader_csum.sv
// rtl/loader_csum.sv - byte-wise XOR accumulator for the optional program checksum
module loader_csum (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       acc_en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;

  // Clear takes priority so a fresh load never inherits the previous sum
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= 8'h00;
    end else if (clr_i) begin
      sum_q <= 8'h00;
    end else if (acc_en_i) begin
      sum_q <= sum_q ^ byte_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader for the 128x16 instruction memory; optional trailing checksum under INST_LOADER_CHECKSUM_EN
module inst_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = LOADER_MAX_WORDS,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          In_Valid,
  input  logic [7:0]    In_Data,
  output logic          In_Ready,
  output logic          Wr_En,
  output logic [AW-1:0] Wr_Addr,
  output logic [DW-1:0] Wr_Data,
  output logic          Busy,
  output logic          Done,
  output logic          Error,
  output logic          Hold_CPU,
  output logic [7:0]    Word_Count
);

  // Largest legal length byte, widened so DEPTH=256 would still compare correctly
  localparam logic [8:0] MAX_LEN = 9'(DEPTH);

  LoaderState    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    lo_q, lo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          accepted;
  logic          start_ok;
  logic          len_legal;

  assign accepted  = In_Valid & In_Ready;
  // Start only matters when no load is running; mid-load pulses are dropped
  assign start_ok  = Start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
  assign len_legal = (In_Data != 8'h00) && ({1'b0, In_Data} <= MAX_LEN);

`ifdef INST_LOADER_CHECKSUM_EN
  logic       csum_clr;
  logic       csum_acc;
  logic [7:0] csum_val;

  // Only data bytes feed the checksum; the length byte is excluded
  assign csum_clr = start_ok;
  assign csum_acc = accepted & ((state_q == HI) | (state_q == LO));

  loader_csum u_csum (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .clr_i    (csum_clr),
    .acc_en_i (csum_acc),
    .byte_i   (In_Data),
    .sum_o    (csum_val)
  );
`endif

  // Next-state logic: walk length, hi/lo byte pairs, write, optional checksum
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          state_d = LEN;
          addr_d  = '0;
          cnt_d   = 8'h00;
        end
      end
      LEN: begin
        if (accepted) begin
          if (len_legal) begin
            len_d   = In_Data;
            state_d = HI;
          end else begin
            state_d = ERR;
          end
        end
      end
      HI: begin
        if (accepted) begin
          hi_d    = In_Data;
          state_d = LO;
        end
      end
      LO: begin
        if (accepted) begin
          lo_d    = In_Data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_d < len_q) begin
          state_d = HI;
        end else begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accepted) begin
          state_d = (In_Data == csum_val) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset returns the CPU to held-in-reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      len_q   <= 8'h00;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      addr_q  <= '0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are pure decodes of registered state, so reset drops them at once
  assign In_Ready   = (state_q == LEN) | (state_q == HI) | (state_q == LO) | (state_q == CSUM);
  assign Busy       = (state_q == LEN) | (state_q == HI) | (state_q == LO) |
                      (state_q == WRITE) | (state_q == CSUM);
  assign Wr_En      = (state_q == WRITE);
  assign Wr_Addr    = addr_q;
  assign Wr_Data    = DW'({hi_q, lo_q});
  assign Done       = (state_q == DONE);
  assign Error      = (state_q == ERR);
  assign Hold_CPU   = (state_q != DONE);
  assign Word_Count = cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader
module tb_inst_loader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        In_Valid;
  logic [7:0]  In_Data;
  logic        In_Ready;
  logic        Wr_En;
  logic [6:0]  Wr_Addr;
  logic [15:0] Wr_Data;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic        Hold_CPU;
  logic [7:0]  Word_Count;

  int checks = 0;
  int errors = 0;
  int base;
  int bad;

  logic [6:0]  log_addr[$];
  logic [15:0] log_data[$];

  inst_loader dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .In_Ready   (In_Ready),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error),
    .Hold_CPU   (Hold_CPU),
    .Word_Count (Word_Count)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Reset && Wr_En) begin
      log_addr.push_back(Wr_Addr);
      log_data.push_back(Wr_Data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    In_Valid = 1'b1;
    In_Data  = b;
    while (In_Ready !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    chk("ready_wait", 32'(t < 50), 32'd1);
    @(negedge Clk);
    In_Valid = 1'b0;
  endtask

  task automatic end_load(input logic [7:0] c);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(c);
`else
    if (c === 8'hxx) In_Data = c;
    @(negedge Clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; In_Valid = 1'b0; In_Data = 8'h00;
    repeat (2) @(negedge Clk);
    chk("rst_ready", In_Ready, 0);
    chk("rst_wren", Wr_En, 0);
    chk("rst_addr", Wr_Addr, 0);
    chk("rst_data", Wr_Data, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_hold", Hold_CPU, 1);
    chk("rst_count", Word_Count, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Two-word load
    base = log_data.size();
    pulse_start();
    chk("start_ready", In_Ready, 1);
    chk("start_busy", Busy, 1);
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("w2_wren", Wr_En, 1);
    chk("w2_addr", Wr_Addr, 1);
    chk("w2_data", Wr_Data, 16'h3344);
    chk("w2_hold_during", Hold_CPU, 1);
    end_load(8'h44);
    chk("w2_done", Done, 1);
    chk("w2_hold", Hold_CPU, 0);
    chk("w2_count", Word_Count, 2);
    chk("w2_ready", In_Ready, 0);
    @(negedge Clk);
    chk("w2_nwrites", log_data.size() - base, 2);
    chk("w2_a0", log_addr[base], 0);
    chk("w2_d0", log_data[base], 16'h1122);
    chk("w2_a1", log_addr[base+1], 1);
    chk("w2_d1", log_data[base+1], 16'h3344);

    // Illegal lengths 00 and 81
    base = log_data.size();
    pulse_start();
    chk("len0_done_clr", Done, 0);
    send_byte(8'h00);
    chk("len0_error", Error, 1);
    chk("len0_hold", Hold_CPU, 1);
    chk("len0_busy", Busy, 0);
    pulse_start();
    chk("len81_err_clr", Error, 0);
    send_byte(8'h81);
    chk("len81_error", Error, 1);
    chk("len81_hold", Hold_CPU, 1);
    chk("len_bad_nwrites", log_data.size() - base, 0);

    // Backpressure between HI and LO with an ignored Start
    base = log_data.size();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hAB);
    repeat (2) @(negedge Clk);
    pulse_start();
    repeat (2) @(negedge Clk);
    chk("bp_wren", Wr_En, 0);
    chk("bp_ready", In_Ready, 1);
    chk("bp_busy", Busy, 1);
    chk("bp_nwrites", log_data.size() - base, 0);
    send_byte(8'hCD);
    chk("bp_addr", Wr_Addr, 0);
    chk("bp_data", Wr_Data, 16'hABCD);
    end_load(8'h66);
    chk("bp_done", Done, 1);
    chk("bp_count", Word_Count, 1);
    @(negedge Clk);
    chk("bp_total", log_data.size() - base, 1);

    // Single-word load; checksum match, then mismatch or trailing byte
    pulse_start();
    send_byte(8'h01); send_byte(8'hA5); send_byte(8'h5A);
    end_load(8'hFF);
    chk("cs_done", Done, 1);
    chk("cs_count", Word_Count, 1);
`ifdef INST_LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h01); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h00);
    chk("cs_bad_error", Error, 1);
    chk("cs_bad_hold", Hold_CPU, 1);
    chk("cs_bad_done", Done, 0);
`else
    In_Valid = 1'b1; In_Data = 8'hFF;
    @(negedge Clk);
    chk("trail_ready", In_Ready, 0);
    chk("trail_done", Done, 1);
    chk("trail_count", Word_Count, 1);
    In_Valid = 1'b0;
`endif

    // Start wins over a presented byte in DONE/ERR; the byte is not consumed
    In_Valid = 1'b1; In_Data = 8'hFF; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; In_Valid = 1'b0;
    chk("startwin_ready", In_Ready, 1);
    chk("startwin_err", Error, 0);
    @(negedge Clk);
    chk("startwin_len", In_Ready & Busy, 1);

    // Full-depth 128-word load
    base = log_data.size();
    send_byte(8'h80);
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
    end
    chk("full_last_addr", Wr_Addr, 7'h7F);
    chk("full_last_data", Wr_Data, 16'h7F80);
    end_load(8'h00);
    chk("full_done", Done, 1);
    chk("full_count", Word_Count, 8'h80);
    chk("full_hold", Hold_CPU, 0);
    @(negedge Clk);
    chk("full_nwrites", log_data.size() - base, 128);
    bad = 0;
    for (int i = 0; i < 128 && base + i < log_data.size(); i++) begin
      if (log_addr[base+i] !== 7'(i) || log_data[base+i] !== {8'(i), ~8'(i)}) bad++;
    end
    chk("full_contents_bad", bad, 0);

    // Reset during the tenth write, then reload from address 0
    pulse_start();
    send_byte(8'h20);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h10 + 8'(i));
      send_byte(8'h20 + 8'(i));
    end
    chk("mid_wren_before", Wr_En, 1);
    chk("mid_addr_before", Wr_Addr, 9);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_wren", Wr_En, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_hold", Hold_CPU, 1);
    chk("mid_rst_count", Word_Count, 0);
    chk("mid_rst_ready", In_Ready, 0);
    chk("mid_rst_addr", Wr_Addr, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    pulse_start();
    send_byte(8'h01); send_byte(8'h77); send_byte(8'h88);
    chk("reload_addr", Wr_Addr, 0);
    chk("reload_data", Wr_Data, 16'h7788);
    end_load(8'hFF);
    chk("reload_done", Done, 1);
    chk("reload_count", Word_Count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that fills the processor's 128 x 16 instruction memory from a byte stream using a valid/ready handshake. It is the writer side of instruction memory: the control unit's fetch path reads what this block writes. The block holds the processor in reset (`Hold_CPU`) while loading and releases it only after a complete, valid program has been written.

## Interface

- Parameters:
  - `DEPTH`, 128: instruction memory words.
  - `AW`, 7: memory address width; `2**AW` must equal `DEPTH`.
  - `DW`, 16: instruction width.
- Ports:
  - `Clk`, input, 1: single clock, rising edge.
  - `Reset`, input, 1: asynchronous, active-high reset.
  - `Start`, input, 1: one-cycle pulse that begins a load.
  - `In_Valid`, input, 1: byte source has data.
  - `In_Data`, input, 8: byte stream.
  - `In_Ready`, output, 1: loader accepts a byte this cycle.
  - `Wr_En`, output, 1: instruction memory write strobe.
  - `Wr_Addr`, output, AW: write address.
  - `Wr_Data`, output, DW: write word.
  - `Busy`, output, 1: a load is in progress.
  - `Done`, output, 1: the last load succeeded (sticky).
  - `Error`, output, 1: the last load failed (sticky).
  - `Hold_CPU`, output, 1: drives processor reset; active high.
  - `Word_Count`, output, 8: number of words written in the current or last load.

## Operation

- **Stream format:**
  - Length byte N comes first.
  - Then 2N bytes, high byte first for each word.
  - Then one checksum byte, only when the checksum feature is compiled in.
- **Valid lengths:** N is 1..DEPTH. N=0 or N>DEPTH enters ERR with no writes.
- **Byte acceptance:** a byte is accepted at a rising edge when `In_Valid & In_Ready`.
- **FSM states:** IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
  - IDLE → LEN on `Start`.
  - LEN → HI on an accepted byte with a legal length, loading N.
  - LEN → ERR on an accepted byte with an illegal length.
  - HI → LO on an accepted byte, capturing the high byte.
  - LO → WRITE on an accepted byte, capturing the low byte.
  - WRITE → HI when `Word_Count` < N after the increment.
  - WRITE → CSUM when `Word_Count` = N and the feature is enabled.
  - WRITE → DONE when `Word_Count` = N and the feature is disabled.
  - CSUM → DONE on an accepted byte equal to the running checksum.
  - CSUM → ERR on an accepted byte that does not match.
  - DONE → LEN on `Start`.
  - ERR → LEN on `Start`.
- **`In_Ready`:** 1 only in LEN, HI, LO and CSUM.
- **WRITE cycle:** `Wr_En`=1, `Wr_Addr`=address counter, `Wr_Data`={hi,lo}. The address counter and `Word_Count` both increment at the end of the cycle.
- **Address counter:** cleared on entry to LEN. It never wraps within a load, because N≤DEPTH.
- **`Busy`:** 1 in LEN, HI, LO, WRITE and CSUM.
- **`Done`:** 1 in DONE only. **`Error`:** 1 in ERR only. Both clear on `Start`.
- **`Hold_CPU`:** 1 in every state except DONE. The processor runs only after a successful load.
- **`Start` while `Busy`:** ignored; the load continues.
- **`Start` in the same cycle as an accepted byte in DONE/ERR:** `Start` wins and the byte is not consumed, because `In_Ready`=0 in those states.
- **Partial loads:** memory words written before an error or reset are not erased. A failed load always leaves `Hold_CPU`=1.

## Timing

- **Reset values:**
  - State = IDLE.
  - `In_Ready`=0, `Wr_En`=0, `Wr_Addr`=0, `Wr_Data`=0.
  - `Busy`=0, `Done`=0, `Error`=0, `Hold_CPU`=1, `Word_Count`=0.
  - Checksum register = 0.
- **Throughput:** minimum 3 cycles per word (HI, LO, WRITE). Stalls on `In_Valid`=0 add cycles without limit.
- **`Start` to `In_Ready`:** 1 cycle; the rising edge samples `Start`, and LEN is active in the next cycle.
- **Last accepted byte to `Done`/`Hold_CPU`:**
  - Checksum disabled: LO byte → WRITE → DONE, so `Done`=1 two cycles after the last data byte's edge.
  - Checksum enabled: `Done`=1 one cycle after the checksum byte's edge.
- **Reset mid-load:** asynchronous. It forces IDLE and all reset values immediately. Any write in progress is dropped (`Wr_En` falls with reset).

## Configuration

- Macro: `INST_LOADER_CHECKSUM_EN`.
- **Defined:**
  - The checksum register XORs every accepted data byte; the length byte is excluded.
  - The register clears on entry to LEN.
  - The CSUM state exists and expects one trailing byte equal to the XOR.
- **Undefined:**
  - No CSUM state and no checksum register.
  - WRITE of the last word goes directly to DONE.
  - A trailing extra byte is not accepted.

## Structure

- Shared package `loader_pkg` holds:
  - enum `LoaderState` {IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR};
  - `LOADER_MAX_WORDS`=128.
- Natural sub-module: `loader_csum`.
  - XOR accumulator with clear and accumulate-enable inputs.
  - Instantiated only under `INST_LOADER_CHECKSUM_EN`.
- The FSM, address counter, byte capture registers and output decode live in `inst_loader`.

## Test plan

- **Reset values:** assert `Reset` mid-run → all outputs at reset values; `Hold_CPU`=1; state IDLE.
- **Two-word load, checksum off:** `Start`, stream 02,11,22,33,44 →
  - writes 0x1122@0 and 0x3344@1;
  - `Word_Count`=2, `Done`=1, `Hold_CPU`=0.
- **Checksum, macro on:** stream 01,A5,5A,FF →
  - one write, then `Done`.
  - Repeat with a final byte of 00 → `Error`=1, `Hold_CPU`=1.
- **Illegal length:** length byte 00 → `Error`=1, no `Wr_En`. Length byte 81 → same result.
- **Backpressure and ignored `Start`:**
  - Deassert `In_Valid` for 5 cycles between HI and LO → no extra writes, correct data.
  - `Start` pulse during the load → ignored.
- **Full-depth load and mid-load reset:**
  - 128-word load → last write at address 0x7F, no wrap, `Word_Count`=128.
  - Reset after word 10 → IDLE. A new `Start` reloads from address 0.
